// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmitter and its peer receiver:
//   FSM state encoding and the fixed line levels.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic UART_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and emits a
//   one-cycle bit_end pulse on the last cycle of every bit period.
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   clr      in   synchronous clear (restart a bit period from zero)
//   en       in   count enable
//   bit_end  out  high on the final cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;

    assign bit_end = en & (baud_cnt_q == LAST_CNT);

    always_comb begin
        baud_cnt_d = baud_cnt_q;
        if (clr || bit_end) begin
            baud_cnt_d = '0;
        end else if (en) begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//   Serialises one byte per frame: start bit, data LSB-first, optional parity,
//   one or two stop bits. Host side is a valid/ready byte interface.
// Ports
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   data_in     in   byte to send, captured on the accept cycle only
//   data_valid  in   host offers data_in
//   data_ready  out  transmitter idle and able to accept this cycle
//   serial      out  registered UART line, idle high
//   busy        out  frame in progress
//
// state  | meaning
// IDLE   | line high, waiting for a byte
// START  | line low for one bit period
// DATA   | shifting out data bits LSB-first
// PARITY | parity of the latched data bits
// STOP   | line high for STOP_BITS bit periods
// -----------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 serial,
    output logic                 busy
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic                 serial_q, serial_d;
    logic                 accept;
    logic                 bit_end;

    assign data_ready = (state_q == IDLE) & ~rst;
    assign accept     = data_valid & data_ready;
    assign busy       = (state_q != IDLE);
    assign serial     = serial_q;

    // Clearing on accept aligns every bit period to the start of the frame.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (state_q != IDLE),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        serial_d   = UART_IDLE;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    shift_d    = data_in;
                    // Parity is fixed at accept time so data_in may move freely afterwards.
                    parity_d   = (^data_in) ^ PARITY_ODD;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        stop_cnt_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is decoded from the next state so serial stays a
        // clean register output and changes exactly on state/bit boundaries.
        case (state_d)
            START:   serial_d = START_LVL;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = parity_d;
            STOP:    serial_d = STOP_LVL;
            default: serial_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            serial_q   <= UART_IDLE;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            serial_q   <= serial_d;
        end
    end

endmodule
